// File: rtl/ysyx_22050078_regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// the a0 register index used by the simulator trap, and the zero word.
package ysyx_22050078_regfile_mp_pkg;

    localparam int CPU_WIDTH   = 64;
    localparam int REG_ADDRW   = 5;
    localparam int NREAD_DEF   = 2;
    localparam int NWRITE_DEF  = 2;
    localparam int A0_IDX      = 10;
    localparam logic [CPU_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/ysyx_22050078_regfile_mp_if.sv
// Bundle of read, write, issue and status signals between the pipeline
// (master) and the register file (slave).
interface ysyx_22050078_regfile_mp_if
    import ysyx_22050078_regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDRW,
    parameter int NREAD      = NREAD_DEF,
    parameter int NWRITE     = NWRITE_DEF
);
    logic [NWRITE-1:0]            wen;
    logic [NWRITE*ADDR_WIDTH-1:0] waddr;
    logic [NWRITE*DATA_WIDTH-1:0] wdata;
    logic [NREAD*ADDR_WIDTH-1:0]  rs_addr;
    logic [NREAD*DATA_WIDTH-1:0]  rs_data;
    logic [NREAD-1:0]             rs_busy;
    logic                         issue_vld;
    logic [ADDR_WIDTH-1:0]        issue_rd;
    logic                         rd_busy;
    logic                         flush;
    logic [ADDR_WIDTH:0]          busy_cnt;
    logic                         s_a0zero;

    modport master (
        output wen, waddr, wdata, rs_addr, issue_vld, issue_rd, flush,
        input  rs_data, rs_busy, rd_busy, busy_cnt, s_a0zero
    );

    modport slave (
        input  wen, waddr, wdata, rs_addr, issue_vld, issue_rd, flush,
        output rs_data, rs_busy, rd_busy, busy_cnt, s_a0zero
    );
endinterface

// File: rtl/ysyx_22050078_rf_scoreboard.sv
// Pending-write tracker: one busy bit per register plus a registered
// population count of the pending set.
module ysyx_22050078_rf_scoreboard
    import ysyx_22050078_regfile_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDRW,
    parameter int NWRITE     = NWRITE_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NWRITE-1:0]            wen,
    input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
    input  logic                         issue_vld,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    input  logic                         flush,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy,
    output logic [ADDR_WIDTH:0]          busy_cnt
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int CW   = ADDR_WIDTH + 1;

    logic [NREG-1:0] busy_reg, busy_next;
    logic [NREG-1:0] clr_vec, set_vec;
    logic [CW-1:0]   busy_cnt_reg, cnt_next;

    // A same-cycle issue outranks writeback (newer producer still in flight);
    // flush outranks both.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NWRITE; i++) begin
            if (wen[i]) clr_vec[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        end
        set_vec = '0;
        if (issue_vld) set_vec[issue_rd] = 1'b1;
        busy_next    = flush ? '0 : ((busy_reg & ~clr_vec) | set_vec);
        busy_next[0] = 1'b0;
        cnt_next = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_next = cnt_next + CW'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= cnt_next;
        end
    end

    assign busy     = busy_reg;
    assign busy_cnt = busy_cnt_reg;
endmodule

// File: rtl/ysyx_22050078_regfile_mp.sv
// Multi-port integer register file with optional write-to-read forwarding
// and a pending-write scoreboard for RAW/WAW hazard detection.
module ysyx_22050078_regfile_mp
    import ysyx_22050078_regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDRW,
    parameter int NREAD      = NREAD_DEF,
    parameter int NWRITE     = NWRITE_DEF,
    parameter int BYPASS     = 1
) (
    input logic                        clk,
    input logic                        rst_n,
    ysyx_22050078_regfile_mp_if.slave  bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int AW   = ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;

    logic [DW-1:0]   regs_reg [NREG];
    logic [NREG-1:0] busy;
    wire  [NREAD*DW-1:0] rs_data_flat;
    wire  [NREAD-1:0]    rs_busy_flat;

    // Ports are visited in ascending order so the last (highest-index)
    // matching write is the one that lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs_reg[r] <= '0;
        end else begin
            for (int i = 0; i < NWRITE; i++) begin
                if (bus.wen[i] && (bus.waddr[i*AW +: AW] != '0))
                    regs_reg[bus.waddr[i*AW +: AW]] <= bus.wdata[i*DW +: DW];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : gen_rd
            logic [AW-1:0] addr;
            logic [DW-1:0] val;
            logic          hit;

            always_comb begin
                addr = bus.rs_addr[gi*AW +: AW];
                val  = regs_reg[addr];
                hit  = 1'b0;
                if (BYPASS != 0) begin
                    for (int i = 0; i < NWRITE; i++) begin
                        if (bus.wen[i] && (bus.waddr[i*AW +: AW] == addr)) begin
                            val = bus.wdata[i*DW +: DW];
                            hit = 1'b1;
                        end
                    end
                end
                if (addr == '0) begin
                    val = '0;
                    hit = 1'b0;
                end
            end

            // A forwarded value is final, so the hazard is hidden for it.
            assign rs_data_flat[gi*DW +: DW] = val;
            assign rs_busy_flat[gi]          = busy[addr] & ~hit;
        end
    endgenerate

    assign bus.rs_data  = rs_data_flat;
    assign bus.rs_busy  = rs_busy_flat;
    assign bus.rd_busy  = busy[bus.issue_rd];
    assign bus.s_a0zero = (regs_reg[A0_IDX] == '0);

    ysyx_22050078_rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NWRITE     (NWRITE)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen       (bus.wen),
        .waddr     (bus.waddr),
        .issue_vld (bus.issue_vld),
        .issue_rd  (bus.issue_rd),
        .flush     (bus.flush),
        .busy      (busy),
        .busy_cnt  (bus.busy_cnt)
    );
endmodule

// File: tb/tb_ysyx_22050078_regfile_mp.sv
// Scoreboard bench: stimulus queues expected observations per cycle, a
// monitor compares them mid low phase against a forwarding and a plain DUT.
module tb_ysyx_22050078_regfile_mp;
    import ysyx_22050078_regfile_mp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   wen;
    logic [9:0]   waddr;
    logic [127:0] wdata;
    logic [9:0]   rs_addr;
    logic         issue_vld;
    logic [4:0]   issue_rd;
    logic         flush;

    ysyx_22050078_regfile_mp_if bus1 ();
    ysyx_22050078_regfile_mp_if bus0 ();

    assign bus1.wen = wen;        assign bus0.wen = wen;
    assign bus1.waddr = waddr;    assign bus0.waddr = waddr;
    assign bus1.wdata = wdata;    assign bus0.wdata = wdata;
    assign bus1.rs_addr = rs_addr; assign bus0.rs_addr = rs_addr;
    assign bus1.issue_vld = issue_vld; assign bus0.issue_vld = issue_vld;
    assign bus1.issue_rd = issue_rd;   assign bus0.issue_rd = issue_rd;
    assign bus1.flush = flush;    assign bus0.flush = flush;

    ysyx_22050078_regfile_mp #(.BYPASS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    ysyx_22050078_regfile_mp #(.BYPASS(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    typedef struct {
        int          kind;
        logic [63:0] val;
        string       name;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit stim_done = 1'b0;

    always @(negedge clk) cyc++;

    function automatic logic [63:0] actual(int kind);
        case (kind)
            0: return bus1.rs_data[63:0];
            1: return bus1.rs_data[127:64];
            2: return 64'(bus1.rs_busy[0]);
            3: return 64'(bus1.rs_busy[1]);
            4: return 64'(bus1.rd_busy);
            5: return 64'(bus1.busy_cnt);
            6: return 64'(bus1.s_a0zero);
            7: return bus0.rs_data[63:0];
            8: return 64'(bus0.rs_busy[0]);
            default: return 64'hBAD;
        endcase
    endfunction

    // Monitor: compares every entry stamped for the current cycle.
    initial begin
        exp_t e;
        logic [63:0] got;
        forever begin
            @(negedge clk);
            #3;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                got = actual(e.kind);
                if (e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL %s: stale entry cyc=%0d now=%0d", e.name, e.cyc, cyc);
                end else if (got !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: cyc=%0d got=0x%h expected=0x%h", e.name, cyc, got, e.val);
                end else begin
                    $display("ok   %s: cyc=%0d value=0x%h", e.name, cyc, got);
                end
            end
        end
    end

    task automatic cyc_begin();
        @(negedge clk);
        #1;
        wen = '0; waddr = '0; wdata = '0; rs_addr = '0;
        issue_vld = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    task automatic wr(int p, int a, logic [63:0] d);
        wen[p] = 1'b1;
        waddr[p*5 +: 5] = 5'(a);
        wdata[p*64 +: 64] = d;
    endtask

    task automatic rd(int p, int a);
        rs_addr[p*5 +: 5] = 5'(a);
    endtask

    task automatic issue(int a);
        issue_vld = 1'b1;
        issue_rd = 5'(a);
    endtask

    task automatic expect_v(int kind, logic [63:0] v, string name);
        exp_q.push_back('{kind, v, name, cyc});
    endtask

    initial begin
        wen = '0; waddr = '0; wdata = '0; rs_addr = '0;
        issue_vld = 1'b0; issue_rd = '0; flush = 1'b0;
        cyc_begin();
        cyc_begin();
        rst_n = 1'b1;
        rd(0, 5);
        expect_v(5, 64'd0, "reset_busy_cnt");
        expect_v(6, 64'd1, "reset_a0zero");
        expect_v(0, 64'd0, "reset_x5");

        // Write/read with and without forwarding
        cyc_begin(); wr(0, 3, 64'hDEAD_BEEF); rd(0, 3); rd(1, 3);
        expect_v(0, 64'hDEAD_BEEF, "bypass_same_cycle");
        expect_v(7, 64'd0, "nobypass_same_cycle");
        expect_v(2, 64'd0, "x3_not_busy");
        cyc_begin(); rd(0, 3);
        expect_v(0, 64'hDEAD_BEEF, "bypass_next_cycle");
        expect_v(7, 64'hDEAD_BEEF, "nobypass_next_cycle");

        // x0 and same-address conflict
        cyc_begin(); wr(0, 0, 64'hFF); rd(0, 0);
        expect_v(0, 64'd0, "x0_write_bypass");
        cyc_begin(); wr(0, 7, 64'd1); wr(1, 7, 64'd2); rd(0, 7); rd(1, 0);
        expect_v(0, 64'd2, "conflict_bypass");
        expect_v(1, 64'd0, "x0_after_write");
        cyc_begin(); rd(0, 7);
        expect_v(0, 64'd2, "conflict_array");
        expect_v(7, 64'd2, "conflict_array_nb");

        // Scoreboard set and writeback clear
        cyc_begin(); issue(9);
        expect_v(4, 64'd0, "rd_busy_before");
        cyc_begin(); rd(0, 9); issue_rd = 5'd9;
        expect_v(2, 64'd1, "x9_rs_busy");
        expect_v(4, 64'd1, "x9_rd_busy");
        expect_v(5, 64'd1, "busy_cnt_1");
        cyc_begin(); wr(0, 9, 64'h99); rd(0, 9);
        expect_v(2, 64'd0, "x9_busy_masked");
        expect_v(0, 64'h99, "x9_fwd");
        expect_v(8, 64'd1, "x9_busy_unmasked_nb");
        expect_v(5, 64'd1, "busy_cnt_still_1");
        cyc_begin(); rd(0, 9);
        expect_v(2, 64'd0, "x9_cleared");
        expect_v(5, 64'd0, "busy_cnt_0");

        // Set beats clear; x0 never reserved
        cyc_begin(); issue(4); wr(0, 4, 64'h44);
        cyc_begin(); rd(0, 4);
        expect_v(2, 64'd1, "x4_set_wins");
        expect_v(5, 64'd1, "busy_cnt_x4");
        cyc_begin(); issue(0);
        cyc_begin(); rd(0, 0); issue_rd = 5'd0;
        expect_v(2, 64'd0, "x0_rs_busy");
        expect_v(4, 64'd0, "x0_rd_busy");
        expect_v(5, 64'd1, "busy_cnt_after_x0");
        cyc_begin(); wr(1, 4, 64'h45);
        cyc_begin();
        expect_v(5, 64'd0, "x4_cleared_cnt");

        // Flush overrides same-cycle issue
        cyc_begin(); issue(1);
        cyc_begin(); issue(2);
        cyc_begin(); issue(3);
        cyc_begin(); rd(0, 1); rd(1, 3);
        expect_v(5, 64'd3, "busy_cnt_3");
        expect_v(2, 64'd1, "x1_busy");
        expect_v(3, 64'd1, "x3_busy");
        flush = 1'b1; issue(6);
        cyc_begin(); rd(0, 6); rd(1, 2);
        expect_v(5, 64'd0, "flush_cnt");
        expect_v(2, 64'd0, "flush_x6");
        expect_v(3, 64'd0, "flush_x2");

        // a0 trap flag is array-based, then async reset mid-run
        cyc_begin(); wr(0, 5, 64'h1234); wr(1, 10, 64'd5); issue(8);
        expect_v(6, 64'd1, "a0zero_not_bypassed");
        cyc_begin(); rd(0, 5);
        expect_v(0, 64'h1234, "x5_written");
        expect_v(6, 64'd0, "a0zero_clear");
        expect_v(5, 64'd1, "busy_cnt_x8");
        cyc_begin(); rd(0, 5); rst_n = 1'b0;
        expect_v(0, 64'd0, "async_rst_x5");
        expect_v(5, 64'd0, "async_rst_cnt");
        expect_v(6, 64'd1, "async_rst_a0zero");
        cyc_begin(); rst_n = 1'b1; rd(0, 5);
        expect_v(0, 64'd0, "post_rst_x5");
        expect_v(7, 64'd0, "post_rst_x5_nb");

        cyc_begin();
        cyc_begin();
        stim_done = 1'b1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue_drain: got=%0d leftover expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
